ctrl_decode_stage: RTL and testbench
====================================

# ctrl_decode_stage

Registered control-decode stage between instruction decode and execute. Each accepted instruction (mode, opcode, S bit, condition field, tag) is decoded into execute/memory/write-back controls and gated by the ARM condition check against the current status flags. The result lands in a 2-entry skid buffer with a valid/ready handshake on both sides. It supports a one-cycle flush for branch recovery and flags undefined encodings.

## Interface
Parameters:
- CMD_W, 4, width of exec_cmd (≥4); ALU codes are zero-extended.
- TAG_W, 32, width of the pass-through tag (PC or destination info).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  discard all buffered and incoming entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_mode  in  2  instruction class: 00 normal, 01 memory, 10 branch, 11 undefined.
- in_opcode  in  4  data-processing opcode.
- in_s  in  1  S bit (load/store select in memory mode).
- in_cond  in  4  condition field.
- in_tag  in  TAG_W  carried unchanged.
- status  in  4  flags {N,Z,C,V}, sampled at acceptance.
- out_valid  out  1  entry at head valid.
- out_ready  in  1  downstream accepts head.
- exec_cmd  out  CMD_W  ALU command.
- mem_read_en, mem_write_en, wb_en, branch_en, s_out  out  1 each  control bits.
- cond_fail  out  1  entry squashed by condition.
- illegal  out  1  undefined encoding.
- out_tag  out  TAG_W  tag of head entry.

## Operation
- Decode, normal mode: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000. All set wb_en=1 and s_out=in_s. CMP 1010→1100 and TST 1000→1110 set s_out=1 and wb_en=0. Any other opcode sets illegal=1 with all enables 0.
- Memory mode: exec_cmd=0010. in_s=1 → mem_read_en=1, wb_en=1 (load). in_s=0 → mem_write_en=1 (store). s_out=0.
- Branch mode: branch_en=1, exec_cmd=0.
- Mode 11: illegal=1, exec_cmd=0, all enables 0.
- Condition: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
- Condition false: the entry is still delivered (out_valid=1) with cond_fail=1 and mem_read_en, mem_write_en, wb_en, branch_en and s_out forced 0. exec_cmd keeps its decoded value. An illegal entry with a false condition has illegal=0.
- Buffer states: EMPTY, ONE (head valid), TWO (head+skid valid).
  - EMPTY --accept--> ONE.
  - ONE --accept & !pop--> TWO.
  - ONE --pop & !accept--> EMPTY.
  - TWO --pop--> ONE, with skid moving to head.
  - accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != TWO), registered.
- flush: next state EMPTY. The input in that cycle is not accepted (in_ready is still observed but ignored).

## Timing
- Reset: state EMPTY, in_ready=1, out_valid=0. exec_cmd, all enables, cond_fail, illegal and out_tag are 0.
- Latency: accept at edge N → out_valid=1 with decoded controls after edge N (same-cycle pop allowed from ONE).
- Throughput: 1 entry/cycle while out_ready=1.
- Outputs stay stable while out_valid=1 & out_ready=0.
- Simultaneous accept+pop in ONE: stays ONE and head is replaced.
- Flush has priority over accept and pop. Reset mid-operation drops all entries immediately.
- status is sampled only on the accept edge. Later flag changes do not affect buffered entries.

## Configuration
- CTRL_COND_EXEC_EN defined: condition evaluation as above.
- CTRL_COND_EXEC_EN undefined: in_cond and status are ignored, every entry executes, and cond_fail is tied 0.

## Test plan
- Reset then MOV (mode 00, op 1101, S=0, cond AL, out_ready=1) → next cycle out_valid=1, exec_cmd=0001, wb_en=1, s_out=0.
- Load (mode 01, S=1) then store (mode 01, S=0) back-to-back → exec_cmd=0010 both; first mem_read_en=1 wb_en=1, second mem_write_en=1 wb_en=0.
- With the macro defined: ADD cond EQ with status 0000 → cond_fail=1, wb_en=0, exec_cmd=0010. Repeat with status 0100 → wb_en=1, cond_fail=0.
- Hold out_ready=0 and push 3 entries → in_ready falls after the 2nd accept and the 3rd is held upstream. Release → tags delivered in order on consecutive cycles.
- Mode 11 and opcode 0011 in mode 00 → illegal=1, all enables 0.
- State TWO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// Control-decode stage: decodes mode/opcode/S/cond into execute controls and buffers them in a 2-entry skid buffer.
// Optional feature macro CTRL_COND_EXEC_EN enables ARM condition evaluation against status {N,Z,C,V}.
module ctrl_decode_stage #(
  parameter int CMD_W = 4,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [3:0]       in_opcode,
  input  logic             in_s,
  input  logic [3:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [3:0]       status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMD_W-1:0] exec_cmd,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             wb_en,
  output logic             branch_en,
  output logic             s_out,
  output logic             cond_fail,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             rd;
    logic             wr;
    logic             wb;
    logic             br;
    logic             s;
    logic             cf;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t state, state_n;
  entry_t head, skid, dec;
  logic   in_ready_q;
  logic   cond_pass;
  logic   accept, pop;
  logic   head_ld_in, head_ld_skid, skid_ld;
  logic [3:0] cmd4;

  // Condition check is evaluated on the accept cycle, so status is sampled exactly once per entry.
`ifdef CTRL_COND_EXEC_EN
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = status;

  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^{in_cond, status};
  assign cond_pass   = 1'b1;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cmd4    = 4'b0000;
    dec     = '0;
    dec.tag = in_tag;
    case (in_mode)
      2'b00: begin
        dec.wb = 1'b1;
        dec.s  = in_s;
        case (in_opcode)
          4'b1101: cmd4 = 4'b0001;
          4'b1111: cmd4 = 4'b1001;
          4'b0100: cmd4 = 4'b0010;
          4'b0101: cmd4 = 4'b0011;
          4'b0010: cmd4 = 4'b0100;
          4'b0110: cmd4 = 4'b0101;
          4'b0000: cmd4 = 4'b0110;
          4'b1100: cmd4 = 4'b0111;
          4'b0001: cmd4 = 4'b1000;
          4'b1010: begin cmd4 = 4'b1100; dec.wb = 1'b0; dec.s = 1'b1; end
          4'b1000: begin cmd4 = 4'b1110; dec.wb = 1'b0; dec.s = 1'b1; end
          default: begin dec.wb = 1'b0; dec.s = 1'b0; dec.ill = 1'b1; end
        endcase
      end
      2'b01: begin
        cmd4   = 4'b0010;
        dec.rd = in_s;
        dec.wb = in_s;
        dec.wr = !in_s;
      end
      2'b10:   dec.br  = 1'b1;
      default: dec.ill = 1'b1;
    endcase
    dec.cmd = CMD_W'(cmd4);
    // A squashed entry still flows downstream so the tag stays ordered; only its side effects are removed.
    if (!cond_pass) begin
      dec.rd  = 1'b0;
      dec.wr  = 1'b0;
      dec.wb  = 1'b0;
      dec.br  = 1'b0;
      dec.s   = 1'b0;
      dec.ill = 1'b0;
      dec.cf  = 1'b1;
    end
  end

  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_n      = state;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      state_n = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) begin state_n = S_ONE; head_ld_in = 1'b1; end
        S_ONE: begin
          if (accept && pop)  head_ld_in = 1'b1;
          else if (accept)    begin state_n = S_TWO; skid_ld = 1'b1; end
          else if (pop)       state_n = S_EMPTY;
        end
        S_TWO:   if (pop) begin state_n = S_ONE; head_ld_skid = 1'b1; end
        default: state_n = S_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != S_TWO);
    end
  end

  // NOTE: the two buffer slots are reset because their contents drive the outputs directly out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_ld_in)        head <= dec;
      else if (head_ld_skid) head <= skid;
      if (skid_ld)           skid <= dec;
    end
  end

  assign in_ready     = in_ready_q;
  assign exec_cmd     = head.cmd;
  assign mem_read_en  = head.rd;
  assign mem_write_en = head.wr;
  assign wb_en        = head.wb;
  assign branch_en    = head.br;
  assign s_out        = head.s;
  assign cond_fail    = head.cf;
  assign illegal      = head.ill;
  assign out_tag      = head.tag;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed vectors push expected entries, a monitor compares on every pop.
// Expectations for condition-gated vectors follow CTRL_COND_EXEC_EN.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        rd, wr, wb, br, s, cf, ill;
    logic [31:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_s, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [3:0]  in_opcode, in_cond, status, exec_cmd;
  logic [31:0] in_tag, out_tag;
  logic        mem_read_en, mem_write_en, wb_en, branch_en, s_out, cond_fail, illegal;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_decode_stage #(.CMD_W(4), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_opcode(in_opcode), .in_s(in_s), .in_cond(in_cond), .in_tag(in_tag),
    .status(status), .out_valid(out_valid), .out_ready(out_ready), .exec_cmd(exec_cmd),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .wb_en(wb_en), .branch_en(branch_en),
    .s_out(s_out), .cond_fail(cond_fail), .illegal(illegal), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] cmd, input logic rd, wr, wb, br, s, cf, ill,
                              input logic [31:0] tag);
    mk = '{cmd, rd, wr, wb, br, s, cf, ill, tag};
  endfunction

  function automatic exp_t cond_exp(input exp_t pass_e);
`ifdef CTRL_COND_EXEC_EN
    cond_exp = mk(pass_e.cmd, 0, 0, 0, 0, 0, 1, 0, pass_e.tag);
`else
    cond_exp = pass_e;
`endif
  endfunction

  task automatic drive(input logic [1:0] m, input logic [3:0] op, input logic s,
                       input logic [3:0] c, input logic [3:0] st, input logic [31:0] tag);
    in_valid = 1'b1; in_mode = m; in_opcode = op; in_s = s; in_cond = c; status = st; in_tag = tag;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] op, input logic s,
                      input logic [3:0] c, input logic [3:0] st, input logic [31:0] tag, input exp_t e);
    int   n = 0;
    logic rdy;
    drive(m, op, s, c, st, tag);
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 50);
    if (rdy) sb.push_back(e);
    else     check("accept_timeout", 64'(rdy), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Monitor: every handshake on the output side consumes one scoreboard entry.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = {exec_cmd, mem_read_en, mem_write_en, wb_en, branch_en, s_out, cond_fail, illegal, out_tag};
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(got), 64'd0);
        end else begin
          e = sb.pop_front();
          check("pop_entry", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_opcode = '0; in_s = 1'b0; in_cond = '0; status = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl", 64'({exec_cmd, mem_read_en, mem_write_en, wb_en, branch_en, s_out, cond_fail, illegal}), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;

    // Main decode vectors, streamed back-to-back with out_ready held high.
    send(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000, 32'd100, mk(4'b0001, 0, 0, 1, 0, 0, 0, 0, 32'd100));
    send(2'b01, 4'b0000, 1'b1, 4'b1110, 4'b0000, 32'd101, mk(4'b0010, 1, 0, 1, 0, 0, 0, 0, 32'd101));
    send(2'b01, 4'b0000, 1'b0, 4'b1110, 4'b0000, 32'd102, mk(4'b0010, 0, 1, 0, 0, 0, 0, 0, 32'd102));
    send(2'b00, 4'b0100, 1'b0, 4'b0000, 4'b0000, 32'd103, cond_exp(mk(4'b0010, 0, 0, 1, 0, 0, 0, 0, 32'd103)));
    send(2'b00, 4'b0100, 1'b0, 4'b0000, 4'b0100, 32'd104, mk(4'b0010, 0, 0, 1, 0, 0, 0, 0, 32'd104));
    send(2'b11, 4'b0000, 1'b1, 4'b1110, 4'b0000, 32'd105, mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 32'd105));
    send(2'b00, 4'b0011, 1'b1, 4'b1110, 4'b0000, 32'd106, mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 32'd106));
    send(2'b00, 4'b1010, 1'b0, 4'b1110, 4'b0000, 32'd107, mk(4'b1100, 0, 0, 0, 0, 1, 0, 0, 32'd107));
    send(2'b10, 4'b0000, 1'b0, 4'b1110, 4'b0000, 32'd108, mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 32'd108));
    send(2'b00, 4'b0010, 1'b1, 4'b1100, 4'b1001, 32'd109, mk(4'b0100, 0, 0, 1, 0, 1, 0, 0, 32'd109));
    send(2'b00, 4'b0001, 1'b1, 4'b1111, 4'b0000, 32'd110, cond_exp(mk(4'b1000, 0, 0, 1, 0, 1, 0, 0, 32'd110)));
`ifdef CTRL_COND_EXEC_EN
    send(2'b11, 4'b0000, 1'b0, 4'b1011, 4'b0000, 32'd111, mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 32'd111));
`else
    send(2'b11, 4'b0000, 1'b0, 4'b1011, 4'b0000, 32'd111, mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 32'd111));
`endif
    send(2'b00, 4'b1000, 1'b0, 4'b1000, 4'b0010, 32'd112, mk(4'b1110, 0, 0, 0, 0, 1, 0, 0, 32'd112));
    send(2'b00, 4'b1100, 1'b0, 4'b1001, 4'b0010, 32'd113, cond_exp(mk(4'b0111, 0, 0, 1, 0, 0, 0, 0, 32'd113)));
    idle(3);

    // Back-pressure: two entries fill the buffer, the third waits upstream.
    out_ready = 1'b0;
    send(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000, 32'd200, mk(4'b0001, 0, 0, 1, 0, 0, 0, 0, 32'd200));
    send(2'b00, 4'b0000, 1'b1, 4'b1110, 4'b0000, 32'd201, mk(4'b0110, 0, 0, 1, 0, 1, 0, 0, 32'd201));
    drive(2'b00, 4'b1111, 1'b0, 4'b1110, 4'b0000, 32'd202);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("hold_tag", 64'(out_tag), 64'd200);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_tag0", 64'(out_tag), 64'd200);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_tag1", 64'(out_tag), 64'd201);
    check("drain_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    sb.push_back(mk(4'b1001, 0, 0, 1, 0, 0, 0, 0, 32'd202));
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_tag2", 64'(out_tag), 64'd202);
    check("drain_valid2", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    idle(2);

    // Asynchronous reset with a buffered entry drops it immediately.
    out_ready = 1'b0;
    send(2'b01, 4'b0000, 1'b1, 4'b1110, 4'b0000, 32'd250, mk(4'b0010, 1, 0, 1, 0, 0, 0, 0, 32'd250));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Flush from TWO: both entries dropped, incoming entry ignored.
    send(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000, 32'd300, mk(4'b0001, 0, 0, 1, 0, 0, 0, 0, 32'd300));
    send(2'b00, 4'b0100, 1'b0, 4'b1110, 4'b0000, 32'd301, mk(4'b0010, 0, 0, 1, 0, 0, 0, 0, 32'd301));
    drive(2'b00, 4'b0010, 1'b0, 4'b1110, 4'b0000, 32'd302);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush2_valid", 64'(out_valid), 64'd0);
    check("flush2_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Flush from ONE while in_ready=1: the presented input must still be refused.
    send(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000, 32'd303, mk(4'b0001, 0, 0, 1, 0, 0, 0, 0, 32'd303));
    drive(2'b10, 4'b0000, 1'b0, 4'b1110, 4'b0000, 32'd304);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush1_valid", 64'(out_valid), 64'd0);
    check("flush1_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);

    // Post-flush traffic still works.
    send(2'b00, 4'b0101, 1'b1, 4'b1110, 4'b0000, 32'd400, mk(4'b0011, 0, 0, 1, 0, 1, 0, 0, 32'd400));
    send(2'b00, 4'b0110, 1'b0, 4'b1110, 4'b0000, 32'd401, mk(4'b0101, 0, 0, 1, 0, 0, 0, 0, 32'd401));
    idle(4);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
